// File: rtl/max_entry.sv
// Two-digit BCD set-point entry (01-99) for the pill counter.
// Edits go to a shadow copy that becomes the live set-point only on an accepted commit.
module max_entry #(
  parameter int unsigned DEF_H   = 2,
  parameter int unsigned DEF_L   = 0,
  parameter int unsigned TMO_CYC = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       key_sel,
  input  logic       key_up,
  input  logic       key_dn,
  input  logic       key_ok,
  input  logic       busy,
  output logic [3:0] maxH,
  output logic [3:0] maxL,
  output logic [3:0] dispH,
  output logic [3:0] dispL,
  output logic       editing,
  output logic       digit,
  output logic       upd,
  output logic       err
);

  localparam int unsigned TW       = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [3:0]    DEF_H4   = 4'(DEF_H);
  localparam logic [3:0]    DEF_L4   = 4'(DEF_L);

  typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_L} state_e;

  state_e        state_q, state_d;
  logic [3:0]    sh_h_q, sh_h_d, sh_l_q, sh_l_d;
  logic [3:0]    max_h_q, max_h_d, max_l_q, max_l_d;
  logic [3:0]    disp_h_q, disp_h_d, disp_l_q, disp_l_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          upd_q, upd_d, err_q, err_d;
  logic          editing_q, editing_d, digit_q, digit_d;
  logic          any_key;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

  assign any_key = key_sel | key_up | key_dn | key_ok;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sh_h_d  = sh_h_q;
    sh_l_d  = sh_l_q;
    max_h_d = max_h_q;
    max_l_d = max_l_q;
    tmo_d   = tmo_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (key_sel && !busy) begin
          state_d = EDIT_H;
          sh_h_d  = max_h_q;
          sh_l_d  = max_l_q;
        end
      end
      EDIT_H, EDIT_L: begin
        if (busy) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else if (any_key) begin
          tmo_d = '0;
          if (key_ok) begin
            if (sh_h_q != 4'd0 || sh_l_q != 4'd0) begin
              max_h_d = sh_h_q;
              max_l_d = sh_l_q;
              upd_d   = 1'b1;
              state_d = IDLE;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_sel) begin
            state_d = (state_q == EDIT_H) ? EDIT_L : EDIT_H;
          end else if (key_up ^ key_dn) begin
            // Digits wrap independently: no carry or borrow into the other digit.
            if (state_q == EDIT_H) sh_h_d = key_up ? bcd_inc(sh_h_q) : bcd_dec(sh_h_q);
            else                   sh_l_d = key_up ? bcd_inc(sh_l_q) : bcd_dec(sh_l_q);
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    editing_d = (state_d != IDLE);
    digit_d   = (state_d == EDIT_H);
    disp_h_d  = editing_d ? sh_h_d : max_h_d;
    disp_l_d  = editing_d ? sh_l_d : max_l_d;
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      sh_h_q    <= DEF_H4;
      sh_l_q    <= DEF_L4;
      max_h_q   <= DEF_H4;
      max_l_q   <= DEF_L4;
      disp_h_q  <= DEF_H4;
      disp_l_q  <= DEF_L4;
      tmo_q     <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      editing_q <= 1'b0;
      digit_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_h_q    <= sh_h_d;
      sh_l_q    <= sh_l_d;
      max_h_q   <= max_h_d;
      max_l_q   <= max_l_d;
      disp_h_q  <= disp_h_d;
      disp_l_q  <= disp_l_d;
      tmo_q     <= tmo_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      editing_q <= editing_d;
      digit_q   <= digit_d;
    end
  end

  assign maxH    = max_h_q;
  assign maxL    = max_l_q;
  assign dispH   = disp_h_q;
  assign dispL   = disp_l_q;
  assign editing = editing_q;
  assign digit   = digit_q;
  assign upd     = upd_q;
  assign err     = err_q;

endmodule

// File: tb/tb_max_entry.sv
// Directed bench for max_entry: reset, edit/commit, wrap, reject 00, busy abort, timeout.
module tb_max_entry;

  logic       CLK = 1'b0;
  logic       RST;
  logic       key_sel, key_up, key_dn, key_ok, busy;
  logic [3:0] maxH, maxL, dispH, dispL;
  logic       editing, digit, upd, err;

  int total = 0;
  int bad   = 0;

  max_entry #(.DEF_H(2), .DEF_L(0), .TMO_CYC(8)) dut (
    .CLK(CLK), .RST(RST),
    .key_sel(key_sel), .key_up(key_up), .key_dn(key_dn), .key_ok(key_ok),
    .busy(busy),
    .maxH(maxH), .maxL(maxL), .dispH(dispH), .dispL(dispL),
    .editing(editing), .digit(digit), .upd(upd), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given key pulses; returns 1 time unit after the edge.
  task automatic cyc(input logic s, input logic u, input logic d, input logic o);
    @(negedge CLK);
    key_sel = s; key_up = u; key_dn = d; key_ok = o;
    @(posedge CLK);
    #1;
    key_sel = 1'b0; key_up = 1'b0; key_dn = 1'b0; key_ok = 1'b0;
  endtask

  initial begin
    RST = 1'b1; busy = 1'b0;
    key_sel = 1'b0; key_up = 1'b0; key_dn = 1'b0; key_ok = 1'b0;
    #3;
    check("rst_maxH", maxH, 8'd2);
    check("rst_maxL", maxL, 8'd0);
    check("rst_dispH", dispH, 8'd2);
    check("rst_dispL", dispL, 8'd0);
    check("rst_editing", editing, 8'd0);
    check("rst_digit", digit, 8'd0);
    check("rst_upd", upd, 8'd0);
    check("rst_err", err, 8'd0);
    @(negedge CLK); RST = 1'b0;

    // Keys other than sel are ignored in IDLE
    cyc(0, 1, 0, 1);
    check("idle_ign_editing", editing, 8'd0);
    check("idle_ign_upd", upd, 8'd0);

    // Edit and commit 35
    cyc(1, 0, 0, 0);
    check("enter_editing", editing, 8'd1);
    check("enter_digit", digit, 8'd1);
    cyc(0, 1, 0, 0);
    check("h_up_dispH", dispH, 8'd3);
    check("h_up_maxH_held", maxH, 8'd2);
    cyc(1, 0, 0, 0);
    check("toggle_digit", digit, 8'd0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    check("l_up5_dispL", dispL, 8'd5);
    check("edit_maxH_held", maxH, 8'd2);
    check("edit_maxL_held", maxL, 8'd0);
    cyc(0, 0, 0, 1);
    check("commit_maxH", maxH, 8'd3);
    check("commit_maxL", maxL, 8'd5);
    check("commit_upd", upd, 8'd1);
    check("commit_editing", editing, 8'd0);
    check("commit_digit", digit, 8'd0);
    cyc(0, 0, 0, 0);
    check("upd_one_cycle", upd, 8'd0);
    check("idle_dispH", dispH, 8'd3);
    check("idle_dispL", dispL, 8'd5);

    // Reset mid-edit: asynchronous return to defaults
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("pre_rst_dispH", dispH, 8'd4);
    RST = 1'b1;
    #1;
    check("async_rst_editing", editing, 8'd0);
    check("async_rst_maxH", maxH, 8'd2);
    check("async_rst_maxL", maxL, 8'd0);
    check("async_rst_dispH", dispH, 8'd2);
    @(negedge CLK); RST = 1'b0;

    // Wrap, no carry/borrow
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("in_edit_l_digit", digit, 8'd0);
    cyc(0, 0, 1, 0);
    check("wrap_dn_dispL", dispL, 8'd9);
    check("wrap_dn_dispH", dispH, 8'd2);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
    check("wrap_up_dispH", dispH, 8'd0);
    check("wrap_up_dispL", dispL, 8'd9);
    cyc(0, 1, 1, 0);
    check("updn_same_dispH", dispH, 8'd0);

    // Reject 00
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("zero_dispL", dispL, 8'd0);
    cyc(0, 0, 0, 1);
    check("rej_err", err, 8'd1);
    check("rej_upd", upd, 8'd0);
    check("rej_editing", editing, 8'd1);
    check("rej_maxH", maxH, 8'd2);
    check("rej_maxL", maxL, 8'd0);
    cyc(0, 1, 0, 0);
    check("err_one_cycle", err, 8'd0);
    check("post_rej_dispL", dispL, 8'd1);
    cyc(0, 0, 0, 1);
    check("commit01_upd", upd, 8'd1);
    check("commit01_maxH", maxH, 8'd0);
    check("commit01_maxL", maxL, 8'd1);

    // Busy abort beats key_ok
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("pre_busy_dispL", dispL, 8'd2);
    busy = 1'b1;
    cyc(0, 0, 0, 1);
    check("busy_editing", editing, 8'd0);
    check("busy_upd", upd, 8'd0);
    check("busy_maxL", maxL, 8'd1);
    check("busy_dispL", dispL, 8'd1);
    cyc(1, 0, 0, 0);
    check("busy_sel_ignored", editing, 8'd0);
    busy = 1'b0;

    // Timeout after last key at edge k
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("tmo_edit_dispH", dispH, 8'd1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
    check("tmo_k7_editing", editing, 8'd1);
    cyc(0, 0, 0, 0);
    check("tmo_k8_editing", editing, 8'd0);
    check("tmo_dispH", dispH, 8'd0);
    check("tmo_dispL", dispL, 8'd1);
    check("tmo_upd", upd, 8'd0);
    check("tmo_maxH", maxH, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
